// File: rtl/x2c_ctrl_reader.sv
// x2c_ctrl_reader: pops header+payload descriptors from the x2c FIFO and turns them into register write bursts
module x2c_ctrl_reader #(
  parameter int WIDTH = 32,
  parameter int AW = 10,
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic             rdclk,
  input  logic             aclr,
  input  logic             enable,
  input  logic             empty,
  input  logic [WIDTH-1:0] q,
  output logic             rdreq,
  output logic             reg_wr,
  output logic [AW-1:0]    reg_addr,
  output logic [WIDTH-1:0] reg_wdata,
  input  logic             reg_ready,
  output logic             cmd_done,
  output logic             err_hdr,
  output logic [15:0]      err_cnt,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, HDR_WAIT, PL_REQ, PL_WAIT, PL_WR, DONE} state_t;
  state_t state, state_n;
  logic       skip;
  logic [9:0] remaining;
  logic       hdr_bad, hdr_zero, last;
  assign hdr_bad  = q[31:24] != SYNC || (q[23:20] != 4'd1 && q[23:20] != 4'd2);
  assign hdr_zero = q[19:10] == 10'd0;
  assign last     = remaining == 10'd1;
  always_ff @(posedge rdclk or posedge aclr)
    if (aclr) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = enable && !empty ? HDR_WAIT : IDLE;
      HDR_WAIT: state_n = hdr_bad || hdr_zero ? IDLE : PL_REQ;
      PL_REQ:   state_n = empty ? PL_REQ : PL_WAIT;
      PL_WAIT:  state_n = !skip ? PL_WR : (last ? DONE : PL_REQ);
      PL_WR:    state_n = !reg_ready ? PL_WR : (last ? DONE : PL_REQ);
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // rdreq is gated by aclr so nothing is popped while reset is held
  always_comb begin
    rdreq    = !aclr && !empty && ((state == IDLE && enable) || state == PL_REQ);
    reg_wr   = state == PL_WR;
    busy     = state != IDLE;
    cmd_done = state == DONE || (state == HDR_WAIT && !hdr_bad && hdr_zero);
    err_hdr  = state == HDR_WAIT && hdr_bad;
  end
  always_ff @(posedge rdclk or posedge aclr)
    if (aclr) begin
      skip      <= 1'b0;
      remaining <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      err_cnt   <= '0;
    end else begin
      if (state == HDR_WAIT && hdr_bad && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (state == HDR_WAIT && !hdr_bad) begin
        remaining <= q[19:10];
        reg_addr  <= q[AW-1:0];
        skip      <= q[23:20] == 4'd2;
      end
      if (state == PL_WAIT) reg_wdata <= q;
      if (state == PL_WAIT && skip) remaining <= remaining - 10'd1;
      if (state == PL_WR && reg_ready) begin
        reg_addr  <= reg_addr + AW'(1);
        remaining <= remaining - 10'd1;
      end
    end
endmodule

// File: tb/tb_x2c_ctrl_reader.sv
// tb_x2c_ctrl_reader: directed bench with a FIFO model and an event logger
module tb_x2c_ctrl_reader;
  logic        rdclk = 0, aclr = 1, enable = 0, reg_ready = 1;
  logic        empty, rdreq, reg_wr, cmd_done, err_hdr, busy;
  logic [31:0] q = 0, reg_wdata;
  logic [9:0]  reg_addr;
  logic [15:0] err_cnt;
  logic [31:0] mem [0:255];
  int rp = 0, wp = 0, total = 0, bad = 0, cyc = 0;
  int rd_n = 0, wr_n = 0, done_n = 0, err_n = 0, viol_empty = 0, viol_hold = 0;
  int rd_c [0:255], wr_c [0:255], done_c [0:255];
  logic [9:0]  wr_a [0:255];
  logic [31:0] wr_d [0:255];
  logic        hold_pend = 0;
  logic [9:0]  h_a;
  logic [31:0] h_d;

  x2c_ctrl_reader dut (.rdclk(rdclk), .aclr(aclr), .enable(enable), .empty(empty), .q(q),
    .rdreq(rdreq), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ready(reg_ready), .cmd_done(cmd_done), .err_hdr(err_hdr), .err_cnt(err_cnt), .busy(busy));

  always #5 rdclk = ~rdclk;
  assign empty = rp == wp;
  always @(posedge rdclk) if (rdreq && !empty) begin
    q  <= mem[rp[7:0]];
    rp <= rp + 1;
  end

  always @(negedge rdclk) begin
    cyc = cyc + 1;
    if (rdreq) begin rd_c[rd_n[7:0]] = cyc; rd_n = rd_n + 1; end
    if (rdreq && empty) viol_empty = viol_empty + 1;
    if (hold_pend && (!reg_wr || reg_addr !== h_a || reg_wdata !== h_d)) viol_hold = viol_hold + 1;
    hold_pend = reg_wr && !reg_ready;
    h_a = reg_addr;
    h_d = reg_wdata;
    if (reg_wr && reg_ready) begin
      wr_a[wr_n[7:0]] = reg_addr; wr_d[wr_n[7:0]] = reg_wdata; wr_c[wr_n[7:0]] = cyc; wr_n = wr_n + 1;
    end
    if (cmd_done) begin done_c[done_n[7:0]] = cyc; done_n = done_n + 1; end
    if (err_hdr) err_n = err_n + 1;
  end

  task automatic tick;
    @(posedge rdclk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wp[7:0]] = w;
    wp = wp + 1;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while ((busy || rp != wp) && k < 200) begin tick(); k++; end
    total++;
    if (k >= 200) begin bad++; $display("FAIL %s idle timeout busy=%0b left=%0d expected idle", nm, busy, wp - rp); end
  endtask

  task automatic test_reset;
    int d0;
    push(32'hA510_0000);
    enable = 1;
    tick(); tick();
    total += 6;
    if (rdreq !== 0)     begin bad++; $display("FAIL reset_rdreq got %b exp 0", rdreq); end
    if (reg_wr !== 0)    begin bad++; $display("FAIL reset_reg_wr got %b exp 0", reg_wr); end
    if (cmd_done !== 0)  begin bad++; $display("FAIL reset_cmd_done got %b exp 0", cmd_done); end
    if (err_hdr !== 0)   begin bad++; $display("FAIL reset_err_hdr got %b exp 0", err_hdr); end
    if (busy !== 0)      begin bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (err_cnt !== 0)   begin bad++; $display("FAIL reset_err_cnt got %h exp 0", err_cnt); end
    d0 = done_n;
    aclr = 0;
    wait_idle("reset_release");
    total++;
    if (done_n - d0 !== 1) begin bad++; $display("FAIL reset_n0_done got %0d exp 1", done_n - d0); end
  endtask

  task automatic test_wr_burst;
    int rb = rd_n, wb = wr_n, db = done_n, k = 0;
    enable = 0;
    push(32'hA510_0FFE); push(32'h11); push(32'h22); push(32'h33);
    tick(); tick();
    total += 2;
    if (rdreq !== 0) begin bad++; $display("FAIL wr_disabled_rdreq got %b exp 0", rdreq); end
    if (busy !== 0)  begin bad++; $display("FAIL wr_disabled_busy got %b exp 0", busy); end
    enable = 1;
    while (done_n == db && k < 40) begin tick(); k++; end
    wait_idle("wr");
    total += 3;
    if (wr_n - wb !== 3) begin bad++; $display("FAIL wr_count got %0d exp 3", wr_n - wb); end
    if (rd_n - rb !== 4) begin bad++; $display("FAIL wr_pops got %0d exp 4", rd_n - rb); end
    if (done_c[db] - rd_c[rb] !== 11) begin bad++; $display("FAIL wr_done_cycle got %0d exp 11", done_c[db] - rd_c[rb]); end
    for (int i = 0; i < 3; i++) begin
      logic [9:0]  ea;
      logic [31:0] ed;
      ea = 10'h3FE + 10'(i);
      ed = 32'h11 * (i + 1);
      total += 3;
      if (wr_a[wb+i] !== ea) begin bad++; $display("FAIL wr_addr%0d got %h exp %h", i, wr_a[wb+i], ea); end
      if (wr_d[wb+i] !== ed) begin bad++; $display("FAIL wr_data%0d got %h exp %h", i, wr_d[wb+i], ed); end
      if (wr_c[wb+i] - rd_c[rb] !== 4 + 3 * i) begin bad++; $display("FAIL wr_cycle%0d got %0d exp %0d", i, wr_c[wb+i] - rd_c[rb], 4 + 3 * i); end
    end
  endtask

  task automatic test_stall;
    int wb = wr_n, db = done_n, k = 0, ve = viol_empty, vh = viol_hold;
    push(32'hA510_0C10); push(32'h44); push(32'h55);
    while (wr_n == wb && k < 40) begin tick(); k++; end
    reg_ready = 0;
    k = 0;
    while (!reg_wr && k < 40) begin tick(); k++; end
    repeat (5) tick();
    total += 3;
    if (reg_wr !== 1)         begin bad++; $display("FAIL stall_hold_wr got %b exp 1", reg_wr); end
    if (reg_addr !== 10'h011) begin bad++; $display("FAIL stall_hold_addr got %h exp 011", reg_addr); end
    if (reg_wdata !== 32'h55) begin bad++; $display("FAIL stall_hold_data got %h exp 55", reg_wdata); end
    reg_ready = 1;
    repeat (4) tick();
    total += 3;
    if (busy !== 1)        begin bad++; $display("FAIL stall_busy got %b exp 1", busy); end
    if (reg_wr !== 0)      begin bad++; $display("FAIL stall_empty_wr got %b exp 0", reg_wr); end
    if (wr_n - wb !== 2)   begin bad++; $display("FAIL stall_partial got %0d exp 2", wr_n - wb); end
    push(32'h66);
    k = 0;
    while (done_n == db && k < 40) begin tick(); k++; end
    wait_idle("stall");
    total += 3;
    if (wr_n - wb !== 3)        begin bad++; $display("FAIL stall_count got %0d exp 3", wr_n - wb); end
    if (viol_empty !== ve)      begin bad++; $display("FAIL stall_rdreq_empty got %0d exp %0d", viol_empty, ve); end
    if (viol_hold !== vh)       begin bad++; $display("FAIL stall_hold_stable got %0d exp %0d", viol_hold, vh); end
    for (int i = 0; i < 3; i++) begin
      total += 2;
      if (wr_a[wb+i] !== 10'h010 + 10'(i)) begin bad++; $display("FAIL stall_addr%0d got %h exp %h", i, wr_a[wb+i], 10'h010 + 10'(i)); end
      if (wr_d[wb+i] !== 32'h44 + 32'(i * 'h11)) begin bad++; $display("FAIL stall_data%0d got %h exp %h", i, wr_d[wb+i], 32'h44 + 32'(i * 'h11)); end
    end
  endtask

  task automatic test_skip_n0;
    int rb = rd_n, wb = wr_n, db = done_n;
    push(32'hA520_0800); push(32'hDEAD); push(32'hBEEF);
    wait_idle("skip");
    total += 3;
    if (rd_n - rb !== 3)   begin bad++; $display("FAIL skip_pops got %0d exp 3", rd_n - rb); end
    if (wr_n - wb !== 0)   begin bad++; $display("FAIL skip_writes got %0d exp 0", wr_n - wb); end
    if (done_n - db !== 1) begin bad++; $display("FAIL skip_done got %0d exp 1", done_n - db); end
    rb = rd_n; db = done_n;
    push(32'hA510_0010);
    wait_idle("n0");
    total += 3;
    if (rd_n - rb !== 1)   begin bad++; $display("FAIL n0_pops got %0d exp 1", rd_n - rb); end
    if (wr_n - wb !== 0)   begin bad++; $display("FAIL n0_writes got %0d exp 0", wr_n - wb); end
    if (done_n - db !== 1) begin bad++; $display("FAIL n0_done got %0d exp 1", done_n - db); end
  endtask

  task automatic test_bad_hdr;
    int eb = err_n, db = done_n;
    push(32'h5A10_0001); push(32'hA510_0000);
    wait_idle("bad");
    total += 3;
    if (err_n - eb !== 1)  begin bad++; $display("FAIL bad_err_pulse got %0d exp 1", err_n - eb); end
    if (err_cnt !== 16'd1) begin bad++; $display("FAIL bad_err_cnt got %h exp 0001", err_cnt); end
    if (done_n - db !== 1) begin bad++; $display("FAIL bad_resync_done got %0d exp 1", done_n - db); end
    force dut.err_cnt = 16'hFFFE;
    #1;
    release dut.err_cnt;
    eb = err_n;
    push(32'h0000_0000); push(32'h1234_5678);
    wait_idle("sat");
    total += 2;
    if (err_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_err_cnt got %h exp FFFF", err_cnt); end
    if (err_n - eb !== 2)     begin bad++; $display("FAIL sat_err_pulse got %0d exp 2", err_n - eb); end
  endtask

  task automatic test_reset_mid;
    int wb = wr_n, eb, k = 0;
    push(32'hA510_0C20); push(32'hAA); push(32'hBB); push(32'hCC);
    while (wr_n == wb && k < 40) begin tick(); k++; end
    aclr = 1;
    #1;
    total += 4;
    if (busy !== 0)    begin bad++; $display("FAIL rmid_busy got %b exp 0", busy); end
    if (reg_wr !== 0)  begin bad++; $display("FAIL rmid_reg_wr got %b exp 0", reg_wr); end
    if (rdreq !== 0)   begin bad++; $display("FAIL rmid_rdreq got %b exp 0", rdreq); end
    if (err_cnt !== 0) begin bad++; $display("FAIL rmid_err_cnt got %h exp 0", err_cnt); end
    tick();
    eb = err_n;
    aclr = 0;
    wait_idle("rmid");
    total += 3;
    if (err_n - eb !== 2)  begin bad++; $display("FAIL rmid_err_pulses got %0d exp 2", err_n - eb); end
    if (err_cnt !== 16'd2) begin bad++; $display("FAIL rmid_err_cnt_after got %h exp 0002", err_cnt); end
    if (wr_n - wb !== 1)   begin bad++; $display("FAIL rmid_writes got %0d exp 1", wr_n - wb); end
  endtask

  initial begin
    test_reset();
    test_wr_burst();
    test_stall();
    test_skip_n0();
    test_bad_hdr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
